// File: rtl/fighter_action_ctrl.sv
// -----------------------------------------------------------------------------
// fighter_action_ctrl
//
// Turns held keyboard keycodes and hit events into per-frame action flags for
// one fighter (punch, jump, crouch, left, right, death). It also tracks health.
// Jump and punch are timed in frames by two small state machines. Death is
// latched until Reset.
//
// Optional feature: define ACTION_INVULN_EN to enable a post-hit
// invulnerability window of INVULN_FRAMES frames.
//
// Ports
//   clk        in   system clock
//   Reset      in   asynchronous reset, active-high
//   frame_clk  in   vsync-rate clock, asynchronous to clk
//   keycode0-3 in   [7:0] held keycode slots (8'h00 = empty)
//   hit        in   one-clk pulse: fighter was struck
//   punch, jump, crouch, left, right, death   out  registered action flags
//   health     out  [3:0] current health
//   invuln     out  invulnerability active (0 when the feature is compiled out)
//
// JUMP_COOL and PUNCH_COOL are expected to be at least 1.
// -----------------------------------------------------------------------------
module fighter_action_ctrl #(
  parameter logic [7:0] KEY_LEFT      = 8'h04,
  parameter logic [7:0] KEY_RIGHT     = 8'h07,
  parameter logic [7:0] KEY_JUMP      = 8'h1A,
  parameter logic [7:0] KEY_CROUCH    = 8'h16,
  parameter logic [7:0] KEY_PUNCH     = 8'h0D,
  parameter int         JUMP_FRAMES   = 12,
  parameter int         JUMP_COOL     = 4,
  parameter int         PUNCH_FRAMES  = 6,
  parameter int         PUNCH_COOL    = 8,
  parameter int         HEALTH_MAX    = 10,
  parameter int         INVULN_FRAMES = 30
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode0,
  input  logic [7:0] keycode1,
  input  logic [7:0] keycode2,
  input  logic [7:0] keycode3,
  input  logic       hit,
  output logic       punch,
  output logic       jump,
  output logic       crouch,
  output logic       left,
  output logic       right,
  output logic       death,
  output logic [3:0] health,
  output logic       invuln
);

  typedef enum logic [1:0] {J_IDLE, J_AIR, J_COOL} jump_state_t;
  typedef enum logic [1:0] {P_IDLE, P_ACT, P_COOL} punch_state_t;

  typedef struct packed {
    logic punch;
    logic jump;
    logic crouch;
    logic left;
    logic right;
  } keys_t;

  // Counters hold "ticks remaining minus one" so that a phase lasts exactly
  // the configured number of ticks after the tick that entered it.
  localparam logic [7:0] J_AIR_LOAD  = 8'(JUMP_FRAMES - 1);
  localparam logic [7:0] J_COOL_LOAD = 8'(JUMP_COOL - 1);
  localparam logic [7:0] P_ACT_LOAD  = 8'(PUNCH_FRAMES - 1);
  localparam logic [7:0] P_COOL_LOAD = 8'(PUNCH_COOL - 1);

  // ---------------------------------------------------------------------------
  // Frame tick: two-flop synchroniser plus one edge-detect flop.
  // ---------------------------------------------------------------------------
  logic [2:0] fsync;
  logic       tick;

  // NOTE: sequential state always uses non-blocking (<=) assignments so every
  // flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) fsync <= '0;
    else       fsync <= {fsync[1:0], frame_clk};
  end

  assign tick = fsync[1] & ~fsync[2];

  // ---------------------------------------------------------------------------
  // Key decode and press edges (sampled at tick).
  // ---------------------------------------------------------------------------
  function automatic logic key_held(input logic [7:0] code,
                                    input logic [7:0] k0, input logic [7:0] k1,
                                    input logic [7:0] k2, input logic [7:0] k3);
    return (k0 == code) | (k1 == code) | (k2 == code) | (k3 == code);
  endfunction

  keys_t held, held_q, press;

  always_comb begin
    held.punch  = key_held(KEY_PUNCH,  keycode0, keycode1, keycode2, keycode3);
    held.jump   = key_held(KEY_JUMP,   keycode0, keycode1, keycode2, keycode3);
    held.crouch = key_held(KEY_CROUCH, keycode0, keycode1, keycode2, keycode3);
    held.left   = key_held(KEY_LEFT,   keycode0, keycode1, keycode2, keycode3);
    held.right  = key_held(KEY_RIGHT,  keycode0, keycode1, keycode2, keycode3);
  end

  assign press = held & ~held_q;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset)     held_q <= '0;
    else if (tick) held_q <= held;
  end

  // ---------------------------------------------------------------------------
  // Health, death and the optional invulnerability window.
  // ---------------------------------------------------------------------------
  logic [3:0] health_q;
  logic       death_q;
  logic       kill;       // death is rising or already latched
  logic       counted_hit;

  assign kill = death_q | (health_q == 4'd0);

`ifdef ACTION_INVULN_EN
  logic [7:0] inv_cnt;

  assign counted_hit = hit & ~death_q & (inv_cnt == 8'd0);

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset)                          inv_cnt <= '0;
    else if (counted_hit)               inv_cnt <= 8'(INVULN_FRAMES);
    else if (tick && inv_cnt != 8'd0)   inv_cnt <= inv_cnt - 8'd1;
  end

  assign invuln = (inv_cnt != 8'd0);
`else
  assign counted_hit = hit & ~death_q;
  assign invuln      = 1'b0;
`endif

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      health_q <= 4'(HEALTH_MAX);
      death_q  <= 1'b0;
    end else begin
      if (counted_hit && health_q != 4'd0) health_q <= health_q - 4'd1;
      if (health_q == 4'd0)                death_q  <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Jump and punch FSMs.
  // ---------------------------------------------------------------------------
  jump_state_t  j_state, j_state_n;
  punch_state_t p_state, p_state_n;
  logic [7:0]   j_cnt, j_cnt_n, p_cnt, p_cnt_n;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      j_state <= J_IDLE;
      p_state <= P_IDLE;
      j_cnt   <= '0;
      p_cnt   <= '0;
    end else begin
      j_state <= j_state_n;
      p_state <= p_state_n;
      j_cnt   <= j_cnt_n;
      p_cnt   <= p_cnt_n;
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    j_state_n = j_state;
    j_cnt_n   = j_cnt;
    p_state_n = p_state;
    p_cnt_n   = p_cnt;

    if (tick) begin
      unique case (j_state)
        J_IDLE: if (press.jump) begin
          j_state_n = J_AIR;
          j_cnt_n   = J_AIR_LOAD;
        end
        J_AIR: if (j_cnt == 8'd0) begin
          j_state_n = J_COOL;
          j_cnt_n   = J_COOL_LOAD;
        end else begin
          j_cnt_n = j_cnt - 8'd1;
        end
        J_COOL: if (j_cnt == 8'd0) j_state_n = J_IDLE;
                else               j_cnt_n   = j_cnt - 8'd1;
        default: j_state_n = J_IDLE;
      endcase

      unique case (p_state)
        P_IDLE: if (press.punch) begin
          p_state_n = P_ACT;
          p_cnt_n   = P_ACT_LOAD;
        end
        P_ACT: if (p_cnt == 8'd0) begin
          p_state_n = P_COOL;
          p_cnt_n   = P_COOL_LOAD;
        end else begin
          p_cnt_n = p_cnt - 8'd1;
        end
        P_COOL: if (p_cnt == 8'd0) p_state_n = P_IDLE;
                else               p_cnt_n   = p_cnt - 8'd1;
        default: p_state_n = P_IDLE;
      endcase
    end

    // Death overrides everything: no landing cooldown, nothing in flight.
    if (kill) begin
      j_state_n = J_IDLE;
      j_cnt_n   = '0;
      p_state_n = P_IDLE;
      p_cnt_n   = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered action flags. jump/punch follow the next FSM state so they
  // change on the same edge as the state itself.
  // ---------------------------------------------------------------------------
  keys_t flags;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      flags <= '0;
    end else if (kill) begin
      flags <= '0;
    end else if (tick) begin
      flags.jump   <= (j_state_n == J_AIR);
      flags.punch  <= (p_state_n == P_ACT);
      flags.crouch <= held.crouch & (j_state_n != J_AIR);
      flags.left   <= held.left;
      flags.right  <= held.right;
    end
  end

  assign punch  = flags.punch;
  assign jump   = flags.jump;
  assign crouch = flags.crouch;
  assign left   = flags.left;
  assign right  = flags.right;
  assign death  = death_q;
  assign health = health_q;

endmodule
